// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter for the write side of a block-RAM FIFO shared by two
//   producers. A producer owns the FIFO write port for a burst of up to BURST
//   words. Ownership passes to the other producer without a dead cycle when
//   the burst ends or the owner drops its request. The FIFO full flag stalls
//   the transfer combinationally but never moves ownership.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset; also masks ack/wr/grant
//   req0/1   : producer i holds a word on data0/1 until acked
//   data0/1  : producer write data (B bits)
//   ack0/1   : producer i word accepted this cycle
//   full     : FIFO full flag
//   wr       : FIFO write strobe
//   wr_data  : FIFO write data (0 when wr is low)
//   grant    : one-hot owner, 01 = producer 0, 10 = producer 1, 00 = none
module fifo_wr_arbiter #(
  parameter int B     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [B-1:0] data0,
  output logic         ack0,
  input  logic         req1,
  input  logic [B-1:0] data1,
  output logic         ack1,
  input  logic         full,
  output logic         wr,
  output logic [B-1:0] wr_data,
  output logic [1:0]   grant
);

  localparam int CNT_W = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  // r_last: 0 = producer 0 released last, 1 = producer 1 released last
  logic             r_last;
  logic             w_last_nxt;
  logic             w_ack0;
  logic             w_ack1;

  // Reset masks the strobes so nothing in flight reaches the FIFO.
  assign w_ack0  = (r_state == OWN0) & req0 & ~full & ~rst;
  assign w_ack1  = (r_state == OWN1) & req1 & ~full & ~rst;
  assign ack0    = w_ack0;
  assign ack1    = w_ack1;
  assign wr      = w_ack0 | w_ack1;
  assign grant   = rst ? 2'b00 : {r_state == OWN1, r_state == OWN0};

  always_comb begin
    wr_data = '0;
    if (w_ack0)      wr_data = data0;
    else if (w_ack1) wr_data = data1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        // Both requesting: the producer that did not own the port last wins.
        if (req0 && req1) w_state_nxt = r_last ? OWN0 : OWN1;
        else if (req0)    w_state_nxt = OWN0;
        else if (req1)    w_state_nxt = OWN1;
      end
      OWN0: begin
        if (w_ack0 && (r_cnt != CNT_MAX)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_ack0 || !req0) begin
          // Release: the other producer takes priority over a re-grant.
          w_last_nxt = 1'b0;
          w_cnt_nxt  = '0;
          if (req1)      w_state_nxt = OWN1;
          else if (req0) w_state_nxt = OWN0;
          else           w_state_nxt = IDLE;
        end
        // Otherwise stalled by full: hold state and count.
      end
      OWN1: begin
        if (w_ack1 && (r_cnt != CNT_MAX)) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (w_ack1 || !req1) begin
          w_last_nxt = 1'b1;
          w_cnt_nxt  = '0;
          if (req0)      w_state_nxt = OWN0;
          else if (req1) w_state_nxt = OWN1;
          else           w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: the stimulus process pushes the
// hand-computed expected outputs of each cycle into a queue; a monitor on the
// falling edge pops and compares them. A second instance built with BURST=1
// shares the inputs and is checked only in its own phase.
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, full;
  logic [7:0] data0, data1;

  logic       ack0_m, ack1_m, wr_m;
  logic [7:0] wd_m;
  logic [1:0] g_m;
  logic       ack0_b, ack1_b, wr_b;
  logic [7:0] wd_b;
  logic [1:0] g_b;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.B(8), .BURST(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0_m),
    .req1(req1), .data1(data1), .ack1(ack1_m),
    .full(full), .wr(wr_m), .wr_data(wd_m), .grant(g_m)
  );

  fifo_wr_arbiter #(.B(8), .BURST(1)) u_dut_b1 (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0_b),
    .req1(req1), .data1(data1), .ack1(ack1_b),
    .full(full), .wr(wr_b), .wr_data(wd_b), .grant(g_b)
  );

  typedef struct {
    string      nm;
    int         id;
    logic       sel;
    logic [1:0] g;
    logic       a0;
    logic       a1;
    logic       w;
    logic [7:0] d;
  } exp_t;

  exp_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    step_id = 0;
  string phase = "init";

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [1:0] g;
      logic a0, a1, w;
      logic [7:0] d;
      e = exp_q.pop_front();
      if (e.sel) begin g = g_b; a0 = ack0_b; a1 = ack1_b; w = wr_b; d = wd_b; end
      else       begin g = g_m; a0 = ack0_m; a1 = ack1_m; w = wr_m; d = wd_m; end
      tests++;
      if (g !== e.g || a0 !== e.a0 || a1 !== e.a1 || w !== e.w || d !== e.d) begin
        fails++;
        $display("FAIL %s step%0d: got grant=%b ack0=%b ack1=%b wr=%b wr_data=%h, want grant=%b ack0=%b ack1=%b wr=%b wr_data=%h",
                 e.nm, e.id, g, a0, a1, w, d, e.g, e.a0, e.a1, e.w, e.d);
      end
    end
  end

  task automatic step(input logic sel, input logic rs,
                      input logic r0, input logic [7:0] d0,
                      input logic r1, input logic [7:0] d1,
                      input logic f,
                      input logic [1:0] eg, input logic ea0, input logic ea1,
                      input logic [7:0] ed);
    exp_t e;
    e.nm = phase; e.id = step_id; e.sel = sel;
    e.g = eg; e.a0 = ea0; e.a1 = ea1; e.w = ea0 | ea1; e.d = ed;
    exp_q.push_back(e);
    step_id++;
    rst = rs; req0 = r0; data0 = d0; req1 = r1; data1 = d1; full = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; full = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Outputs masked while reset is high, even with requests present.
    phase = "reset";
    step(0, 1, 1, 8'h41, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);

    // Single producer: grant after one edge, burst of 4, re-grant, drop.
    phase = "burst0";
    step(0, 0, 1, 8'h41, 0, 8'h00, 0, 2'b00, 0, 0, 8'h00);
    repeat (4) step(0, 0, 1, 8'h41, 0, 8'h00, 0, 2'b01, 1, 0, 8'h41);
    step(0, 0, 1, 8'h41, 0, 8'h00, 0, 2'b01, 1, 0, 8'h41);
    step(0, 0, 0, 8'h41, 0, 8'h00, 0, 2'b01, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 0, 8'h00);

    // Both requesting from reset: 0x10 x4, 0x20 x4, 0x10 x4, no gaps.
    phase = "rr";
    step(0, 1, 1, 8'h10, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);
    step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);
    repeat (4) step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b01, 1, 0, 8'h10);
    repeat (4) step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b10, 0, 1, 8'h20);
    repeat (4) step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b01, 1, 0, 8'h10);
    // Owner 1 drops before any word: hands over to producer 0.
    step(0, 0, 1, 8'h10, 0, 8'h20, 0, 2'b10, 0, 0, 8'h00);

    // Full stall at cnt=2 holds grant and count; 2 more words then handover.
    phase = "full";
    repeat (2) step(0, 0, 1, 8'h10, 0, 8'h20, 0, 2'b01, 1, 0, 8'h10);
    repeat (3) step(0, 0, 1, 8'h10, 1, 8'h20, 1, 2'b01, 0, 0, 8'h00);
    repeat (2) step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b01, 1, 0, 8'h10);

    // Owner 1 drops after one word while producer 0 waits.
    phase = "drop1";
    step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b10, 0, 1, 8'h20);
    step(0, 0, 1, 8'h10, 0, 8'h20, 0, 2'b10, 0, 0, 8'h00);
    step(0, 0, 1, 8'h10, 0, 8'h20, 0, 2'b01, 1, 0, 8'h10);
    step(0, 0, 0, 8'h10, 0, 8'h20, 0, 2'b01, 0, 0, 8'h00);

    // Producer 0 released last, so contention from IDLE goes to producer 1.
    phase = "last";
    step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);
    repeat (2) step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b10, 0, 1, 8'h20);

    // Reset mid-burst: no write, back to IDLE, producer 0 first afterwards.
    phase = "rstmid";
    step(0, 1, 1, 8'h10, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);
    step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);
    step(0, 0, 1, 8'h10, 1, 8'h20, 0, 2'b01, 1, 0, 8'h10);

    // Request drop while full still releases.
    phase = "fulldrop";
    step(0, 0, 0, 8'h10, 1, 8'h20, 1, 2'b01, 0, 0, 8'h00);
    step(0, 0, 0, 8'h10, 1, 8'h20, 0, 2'b10, 0, 1, 8'h20);
    step(0, 0, 0, 8'h10, 0, 8'h20, 0, 2'b10, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00, 0, 8'h00, 0, 2'b00, 0, 0, 8'h00);

    // BURST=1 instance alternates every cycle.
    phase = "burst1";
    step(1, 1, 1, 8'h10, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);
    step(1, 0, 1, 8'h10, 1, 8'h20, 0, 2'b00, 0, 0, 8'h00);
    repeat (2) begin
      step(1, 0, 1, 8'h10, 1, 8'h20, 0, 2'b01, 1, 0, 8'h10);
      step(1, 0, 1, 8'h10, 1, 8'h20, 0, 2'b10, 0, 1, 8'h20);
    end
    step(1, 0, 1, 8'h10, 1, 8'h20, 0, 2'b01, 1, 0, 8'h10);

    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked records, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the block-RAM FIFO between two producers. Each producer presents a request with data; the arbiter grants the FIFO write port to one producer at a time for bursts of up to BURST words and honours the FIFO `full` flag. It sits directly in front of the FIFO `wr`/`wr_data` inputs. The FIFO read side is untouched.

## Interface
Parameters:
- B, 8, data width in bits; matches the FIFO word width.
- BURST, 4, maximum words accepted from one producer per grant; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  producer 0 has a word on `data0`.
- data0  in  B  producer 0 write data.
- ack0  out  1  producer 0 word accepted this cycle.
- req1  in  1  producer 1 has a word on `data1`.
- data1  in  B  producer 1 write data.
- ack1  out  1  producer 1 word accepted this cycle.
- full  in  1  FIFO full flag.
- wr  out  1  FIFO write strobe.
- wr_data  out  B  FIFO write data.
- grant  out  2  one-hot current owner: 01 = producer 0, 10 = producer 1, 00 = none.

## Operation
- State machine has three states: IDLE, OWN0, OWN1. Registers: `state`, burst counter `cnt` (width clog2(BURST)+1), and `last` (last owner).
- `grant` is decoded from `state`.
- `ack_i = (state==OWNi) & req_i & ~full` (combinational).
- `wr = ack0 | ack1`.
- `wr_data` is `data_i` of the owner when `wr` is 1, otherwise 0.
- A producer holds `req_i` and keeps `data_i` stable until it sees `ack_i`. One word transfers per `ack` cycle.
- IDLE:
  - Exactly one producer requests: go to that producer's OWN state.
  - Both request: go to the producer that is not `last`.
  - No request: stay in IDLE.
  - `cnt` is cleared to 0 on entering any OWN state.
- OWNi, evaluated at each edge:
  - `ack_i` and `cnt==BURST-1`: release.
  - Otherwise, `ack_i`: increment `cnt`, stay.
  - Otherwise, `~req_i`: release.
  - Otherwise (full stall): hold state and `cnt`.
- Release from OWNi:
  - Set `last=i`.
  - Next state is OWN(other) if `req_other`; else OWNi with `cnt=0` if `req_i`; else IDLE.
- Arithmetic:
  - `cnt` never exceeds BURST-1.
  - BURST=1 releases after every accepted word.

## Timing
- Reset values: `state`=IDLE, `cnt`=0, `last`=1 (producer 0 has first priority).
- Outputs during reset: `ack0`=`ack1`=0, `wr`=0, `wr_data`=0, `grant`=00.
- Grant latency from IDLE: a request sampled at edge N gives `grant` valid after N and the first `ack` in cycle N+1 (if not full).
- Handover between producers: zero dead cycles. The new owner can be acked in the cycle right after the previous owner's last ack.
- `full`:
  - Blocks `ack`/`wr` combinationally in the same cycle.
  - Never changes ownership by itself.
  - A req drop during full still releases.
- Simultaneous burst end and other-request: the other producer always wins; the current owner cannot retain the grant while the other requests.
- A request dropped mid-burst releases at the next edge; the unfinished burst count is discarded.
- `rst` asserted mid-burst: return to IDLE next edge; in-flight data is not written (`wr` forced 0 while `rst` is high).
- `wr` is never asserted when `full` is 1, and never asserted for two producers in the same cycle.

## Test plan
- Reset, then `req0`=1 with `data0`=0x41 held, `full`=0 → `grant`=01 after 1 edge; `ack0`/`wr` high with `wr_data`=0x41 for 4 consecutive cycles; release; re-grant to producer 0 with `cnt`=0 (no contention).
- Both requests held from IDLE after reset, `data0`=0x10, `data1`=0x20 → writes 0x10 ×4, then 0x20 ×4, then 0x10 ×4; no gap cycles between bursts.
- OWN0 with `cnt`=2, drive `full`=1 for 3 cycles → `ack0`=`wr`=0, `grant` stays 01, `cnt` stays 2. After `full`=0 → exactly 2 more words, then handover.
- OWN1, drop `req1` after 1 word while `req0`=1 → `grant`=01 on the next edge; `last`=1 is recorded.
- BURST=1 build, both requesting → `wr_data` alternates 0x10, 0x20, 0x10 every cycle.
- Assert `rst` during OWN1 mid-burst → next cycle `grant`=00, `wr`=0, `cnt`=0. Afterwards, simultaneous requests are granted to producer 0 first.
